// File: rtl/fetch_queue_if.sv
// Handshake bundle between IF2 (producer), the fetch queue and ID (consumer).
// The queue takes the slave view; the driving environment takes the master view.
interface fetch_queue_if #(
    parameter int DEPTH  = 4,
    parameter int SIDE_W = 5
);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              in_pc;
    logic [31:0]              in_inst;
    logic                     in_inst_valid;
    logic [SIDE_W-1:0]        in_side;
    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              out_pc;
    logic [31:0]              out_inst;
    logic [SIDE_W-1:0]        out_side;
    logic                     out_after_flush;
    logic [$clog2(DEPTH):0]   count;

    modport slave (
        input  flush, in_valid, in_pc, in_inst, in_inst_valid, in_side, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_side, out_after_flush, count
    );

    modport master (
        output flush, in_valid, in_pc, in_inst, in_inst_valid, in_side, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_side, out_after_flush, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular-buffer queue between IF2 and ID; outputs come straight from storage
// so a pushed entry is visible one cycle later at the earliest.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int SIDE_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.slave  fq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]       pc_q   [DEPTH];
    logic [31:0]       inst_q [DEPTH];
    logic [SIDE_W-1:0] side_q [DEPTH];
    logic              af_q   [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          after_flush_pending_q, after_flush_pending_d;
    logic          push, pop;

    assign fq.in_ready  = (count_q < CW'(DEPTH));
    assign fq.out_valid = (count_q != '0);
    assign fq.count     = count_q;

    assign push = fq.in_valid  && fq.in_ready  && !fq.flush;
    assign pop  = fq.out_valid && fq.out_ready && !fq.flush;

    always_comb begin
        head_d                = head_q;
        tail_d                = tail_q;
        count_d               = count_q;
        after_flush_pending_d = after_flush_pending_q;
        if (fq.flush) begin
            head_d                = '0;
            tail_d                = '0;
            count_d               = '0;
            after_flush_pending_d = 1'b1;
        end else begin
            // DEPTH is a power of two, so pointer increment wraps naturally.
            if (push) begin
                tail_d                = tail_q + 1'b1;
                after_flush_pending_d = 1'b0;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q                <= '0;
            tail_q                <= '0;
            count_q               <= '0;
            after_flush_pending_q <= 1'b1;
        end else begin
            head_q                <= head_d;
            tail_q                <= tail_d;
            count_q               <= count_d;
            after_flush_pending_q <= after_flush_pending_d;
        end
    end

    // Storage is never cleared; out_valid gating hides stale contents.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            pc_q[tail_q]   <= fq.in_pc;
            inst_q[tail_q] <= fq.in_inst_valid ? fq.in_inst : 32'h0;
            side_q[tail_q] <= fq.in_side;
            af_q[tail_q]   <= after_flush_pending_q;
        end
    end

    assign fq.out_pc          = fq.out_valid ? pc_q[head_q]   : 32'h0;
    assign fq.out_inst        = fq.out_valid ? inst_q[head_q] : 32'h0;
    assign fq.out_side        = fq.out_valid ? side_q[head_q] : '0;
    assign fq.out_after_flush = fq.out_valid ? af_q[head_q]   : 1'b0;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed scoreboard bench for fetch_queue: stimulus pushes expected entries,
// a negedge monitor pops and compares on every ID handshake.
module tb_fetch_queue;
    localparam int DEPTH  = 4;
    localparam int SIDE_W = 5;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       inst;
        logic [SIDE_W-1:0] side;
        logic              af;
    } entry_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    bit   done;
    int   mcount;
    bit   mafp;
    entry_t sb[$];

    fetch_queue_if #(.DEPTH(DEPTH), .SIDE_W(SIDE_W)) fq ();

    fetch_queue #(.DEPTH(DEPTH), .SIDE_W(SIDE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fq    (fq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: consumes one expected entry per accepted pop.
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            if (!done && rst_n === 1'b1 && fq.flush === 1'b0) begin
                if (fq.out_valid === 1'b1 && fq.out_ready === 1'b1) begin
                    if (sb.size() == 0) begin
                        chk("pop_with_empty_scoreboard", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("out_pc",          64'(fq.out_pc),          64'(e.pc));
                        chk("out_inst",        64'(fq.out_inst),        64'(e.inst));
                        chk("out_side",        64'(fq.out_side),        64'(e.side));
                        chk("out_after_flush", 64'(fq.out_after_flush), 64'(e.af));
                    end
                end else if (fq.out_valid === 1'b0) begin
                    chk("idle_out_zero",
                        {fq.out_pc, fq.out_inst[26:0], fq.out_side},
                        64'd0);
                    chk("idle_af_zero", 64'(fq.out_after_flush), 64'd0);
                end
            end
        end
    end

    // One clock of stimulus: drive, check state at negedge, advance the model.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic iv, input logic [SIDE_W-1:0] side,
                        input logic ordy, input logic fl, input logic rn);
        bit push_m, pop_m;
        entry_t e;
        fq.in_valid      = v;
        fq.in_pc         = pc;
        fq.in_inst       = inst;
        fq.in_inst_valid = iv;
        fq.in_side       = side;
        fq.out_ready     = ordy;
        fq.flush         = fl;
        rst_n            = rn;
        @(negedge clk);
        chk("count",     64'(fq.count),     64'(mcount));
        chk("in_ready",  64'(fq.in_ready),  64'(mcount < DEPTH));
        chk("out_valid", 64'(fq.out_valid), 64'(mcount != 0));
        if (!rn) begin
            mcount = 0;
            mafp   = 1'b1;
            sb.delete();
        end else if (fl) begin
            mcount = 0;
            mafp   = 1'b1;
            sb.delete();
        end else begin
            push_m = v && (mcount < DEPTH);
            pop_m  = ordy && (mcount != 0);
            if (push_m) begin
                e.pc   = pc;
                e.inst = iv ? inst : 32'h0;
                e.side = side;
                e.af   = mafp;
                sb.push_back(e);
                mafp = 1'b0;
            end
            mcount = mcount + int'(push_m) - int'(pop_m);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst,
                        input logic [SIDE_W-1:0] side, input logic ordy);
        step(1'b1, pc, inst, 1'b1, side, ordy, 1'b0, 1'b1);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, 32'h0, 1'b0, '0, ordy, 1'b0, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        done     = 1'b0;
        mcount   = 0;
        mafp     = 1'b1;
        rst_n            = 1'b0;
        fq.flush         = 1'b0;
        fq.in_valid      = 1'b0;
        fq.in_pc         = '0;
        fq.in_inst       = '0;
        fq.in_inst_valid = 1'b0;
        fq.in_side       = '0;
        fq.out_ready     = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 32'hDEAD0000, 32'h1, 1'b1, 5'h1F, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

        // First entry after reset carries after_flush.
        push(32'h1C000000, 32'h02800000, 5'b00011, 1'b0);
        chk("first_out_pc",   64'(fq.out_pc),   64'h1C000000);
        chk("first_out_inst", 64'(fq.out_inst), 64'h02800000);
        chk("first_af",       64'(fq.out_after_flush), 64'd1);
        idle(1'b1);

        // Two fills with a rejected fifth offer each; pointers start at 1 so both wrap.
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < DEPTH; i++)
                push(32'h1C000100 + 32'(f * 32'h100) + 32'(i * 4), 32'h00100000 + 32'(i),
                     5'(i + f), 1'b0);
            chk("full_count",    64'(fq.count),    64'd4);
            chk("full_in_ready", 64'(fq.in_ready), 64'd0);
            push(32'h1C0F0000, 32'hBAD0BAD0, 5'h1F, 1'b0);
            drain();
        end

        // Simultaneous push and pop at count 2.
        push(32'h1C000A00, 32'hA, 5'h0A, 1'b0);
        push(32'h1C000B00, 32'hB, 5'h0B, 1'b0);
        push(32'h1C000C00, 32'hC, 5'h0C, 1'b1);
        chk("pushpop_count", 64'(fq.count), 64'd2);
        chk("pushpop_head",  64'(fq.out_pc), 64'h1C000B00);
        drain();

        // Flush at count 3 with push and pop requested; then held flush.
        push(32'h1C001000, 32'h10, 5'h01, 1'b0);
        push(32'h1C001004, 32'h14, 5'h02, 1'b0);
        push(32'h1C001008, 32'h18, 5'h03, 1'b0);
        step(1'b1, 32'h1C00100C, 32'h1C, 1'b1, 5'h04, 1'b1, 1'b1, 1'b1);
        chk("flush_count",  64'(fq.count),  64'd0);
        chk("flush_out_pc", 64'(fq.out_pc), 64'd0);
        step(1'b1, 32'h1C001010, 32'h20, 1'b1, 5'h05, 1'b1, 1'b1, 1'b1);
        push(32'h1C002000, 32'h30, 5'h06, 1'b0);
        push(32'h1C002004, 32'h34, 5'h07, 1'b0);
        drain();

        // Invalid icache data is stored as zero; sideband untouched.
        step(1'b1, 32'h1C003000, 32'hFFFFFFFF, 1'b0, 5'b10101, 1'b0, 1'b0, 1'b1);
        chk("zero_inst", 64'(fq.out_inst), 64'd0);
        chk("side_kept", 64'(fq.out_side), 64'b10101);
        drain();

        // Reset while full, with push and pop requested.
        for (int i = 0; i < DEPTH; i++)
            push(32'h1C004000 + 32'(i * 4), 32'h40 + 32'(i), 5'(i), 1'b0);
        step(1'b1, 32'h1C004010, 32'h50, 1'b1, 5'h08, 1'b1, 1'b0, 1'b0);
        chk("rst_count",     64'(fq.count),     64'd0);
        chk("rst_in_ready",  64'(fq.in_ready),  64'd1);
        chk("rst_out_valid", 64'(fq.out_valid), 64'd0);
        push(32'h1C005000, 32'h60, 5'h09, 1'b0);
        push(32'h1C005004, 32'h64, 5'h0A, 1'b1);
        drain();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of queue entries (power of two, >=2).
REQ-002 The block SHALL have parameter SIDE_W, default 5, meaning the width of per-entry sideband (adef, icache hit, branch predict, bht, ghr).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  discard all entries and any same-cycle push or pop.
REQ-006 in_valid  input  1  IF2 offers an entry.
REQ-007 in_ready  output  1  queue can accept an entry this cycle.
REQ-008 in_pc  input  32  fetch PC.
REQ-009 in_inst  input  32  fetched instruction.
REQ-010 in_inst_valid  input  1  icache data valid; if low, the instruction is stored as zero.
REQ-011 in_side  input  SIDE_W  sideband bits, stored unmodified.
REQ-012 out_valid  output  1  head entry present for ID.
REQ-013 out_ready  input  1  ID consumes the head entry.
REQ-014 out_pc / out_inst / out_side  output  32/32/SIDE_W  head entry fields.
REQ-015 out_after_flush  output  1  head entry is the first entry accepted after reset or flush.
REQ-016 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-017 Storage SHALL be a circular buffer with head and tail pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-018 push = in_valid && in_ready && !flush; pop = out_valid && out_ready && !flush.
REQ-019 in_ready SHALL equal (count < DEPTH) and SHALL NOT depend on out_ready; a full queue does not accept a push even when a pop occurs in the same cycle.
REQ-020 out_valid SHALL equal (count != 0); out_pc, out_inst, out_side and out_after_flush SHALL read the head entry directly from storage with no combinational path from in_* to out_*.
REQ-021 When out_valid is 0, out_pc, out_inst, out_side and out_after_flush SHALL all be 0.
REQ-022 Latency: an entry pushed in cycle N SHALL be visible at the outputs no earlier than cycle N+1 (no bypass, including when the queue is empty).
REQ-023 On push, the entry SHALL store in_pc, in_side and (in_inst_valid ? in_inst : 0) at the tail, and the tail SHALL advance.
REQ-024 On pop, the head SHALL advance.
REQ-025 count SHALL increment on push-only, decrement on pop-only, and stay unchanged on simultaneous push and pop.
REQ-026 Entries SHALL leave in strict FIFO order.
REQ-027 An internal flag after_flush_pending SHALL be set by reset or flush; the next pushed entry SHALL store after_flush=1 and clear the flag; all other entries SHALL store 0.
REQ-028 When flush is high in cycle N, in cycle N+1: count=0, head=tail=0, out_valid=0, in_ready=1, after_flush_pending=1; a push or pop requested in cycle N SHALL have no effect.
REQ-029 While flush stays high, the queue SHALL remain empty and accept nothing.
REQ-030 Storage contents need not be cleared on flush; the outputs SHALL still obey REQ-021.

Reset
REQ-031 While rst_n=0 at a clock edge: count=0, head=tail=0, after_flush_pending=1; outputs settle to out_valid=0, in_ready=1, and all out_* data 0.
REQ-032 Reset asserted mid-operation SHALL discard all entries in the same manner as flush; reset SHALL take priority over flush, push and pop.

Verification
REQ-033 Reset, then push pc=0x1C000000 inst=0x02800000 in_inst_valid=1 -> next cycle out_valid=1, out_pc=0x1C000000, out_inst=0x02800000, out_after_flush=1, count=1.
REQ-034 DEPTH=4: hold out_ready=0 and push 4 entries -> count=4, in_ready=0; a 5th in_valid is not accepted; pop all with out_ready=1 -> PCs come out in order and pointer wrap is exercised across two fills.
REQ-035 With count=2, push and pop in the same cycle -> count stays 2 and the next head is the second entry.
REQ-036 With count=3, raise flush together with in_valid and out_ready -> next cycle count=0, out_valid=0, out_pc=0; the next push has out_after_flush=1 and the push after it has out_after_flush=0.
REQ-037 Push with in_inst_valid=0, in_inst=0xFFFFFFFF, in_side=5'b10101 -> head out_inst=0 and out_side=5'b10101.
REQ-038 With a full queue, pull rst_n low for one cycle -> count=0, in_ready=1, out_valid=0.
